xbox_xlr_mac_seq: RTL



---
 rtl/xbox_xlr_mac_seq_if.sv | 41 ++++
 rtl/xbox_xlr_mac_seq.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/xbox_xlr_mac_seq_if.sv
// Host-register, memory and row-MAC signal bundle for the
// matrix-vector sequencer.
interface xbox_xlr_mac_seq_if #(
  parameter int LOG2_LINES_PER_MEM = 4
);
  logic [31:0][31:0]                    host_regs;
  logic [31:0]                          host_regs_valid_pulse;
  logic [31:0][31:0]                    host_regs_data_out;
  logic [31:0]                          host_regs_valid_out;
  logic [1:0][LOG2_LINES_PER_MEM-1:0]   xlr_mem_addr;
  logic [1:0][7:0][31:0]                xlr_mem_wdata;
  logic [1:0][31:0]                     xlr_mem_be;
  logic [1:0]                           xlr_mem_rd;
  logic [1:0]                           xlr_mem_wr;
  logic [1:0][7:0][31:0]                xlr_mem_rdata;
  logic                                 mac_start;
  logic                                 mac_valid;
  logic                                 mac_last;
  logic [7:0][31:0]                     mac_a;
  logic [7:0][31:0]                     mac_b;
  logic                                 mac_done;
  logic [31:0]                          mac_result;

  modport master (
    input  host_regs, host_regs_valid_pulse,
    input  xlr_mem_rdata, mac_done, mac_result,
    output host_regs_data_out, host_regs_valid_out,
    output xlr_mem_addr, xlr_mem_wdata, xlr_mem_be,
    output xlr_mem_rd, xlr_mem_wr,
    output mac_start, mac_valid, mac_last, mac_a, mac_b
  );

  modport slave (
    output host_regs, host_regs_valid_pulse,
    output xlr_mem_rdata, mac_done, mac_result,
    input  host_regs_data_out, host_regs_valid_out,
    input  xlr_mem_addr, xlr_mem_wdata, xlr_mem_be,
    input  xlr_mem_rd, xlr_mem_wr,
    input  mac_start, mac_valid, mac_last, mac_a, mac_b
  );
endinterface

// File: rtl/xbox_xlr_mac_seq.sv
// Matrix-vector sequencer: streams A rows and vector B into a row MAC
// and writes each row result back into mem1.
module xbox_xlr_mac_seq #(
  parameter int LOG2_LINES_PER_MEM = 4,
  parameter int NUM_MEMS           = 2
) (
  input  logic             clk,
  input  logic             rst,
  xbox_xlr_mac_seq_if.master bus
);
  localparam int L = LOG2_LINES_PER_MEM;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RUN  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_FIN  = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [31:0] row_q, row_d;
  logic [31:0] k_q, k_d;
  logic [31:0] len_q, len_d;
  logic [31:0] nrows_q, nrows_d;
  logic [31:0] abase_q, abase_d;
  logic [31:0] bbase_q, bbase_d;
  logic [31:0] rbase_q, rbase_d;
  logic [31:0] res_q, res_d;
  logic [31:0] rdone_q, rdone_d;
  logic        done_q, done_d;
  logic        v1_q, v1_d;
  logic        v9_q, v9_d;
  logic        mv_q, mv_d;
  logic        ml_q, ml_d;

  logic         go;
  logic         k_last;
  logic [L-1:0] a_addr;
  logic [L-1:0] b_addr;
  logic [L-1:0] r_addr;
  logic         unused;

  assign unused = ^{bus.host_regs[31:9], bus.host_regs[7],
                    bus.host_regs[1:0],
                    bus.host_regs_valid_pulse[31:9],
                    bus.host_regs_valid_pulse[7:0],
                    NUM_MEMS[0]};

  // Addresses are formed at full width, then wrap to the memory size.
  assign a_addr = L'(abase_q + row_q * len_q + k_q);
  assign b_addr = L'(bbase_q + k_q);
  assign r_addr = L'(rbase_q + (row_q >> 3));

  assign go = bus.host_regs_valid_pulse[8] &
              (bus.host_regs[8] != '0);
  assign k_last = (k_q == len_q - 32'd1);

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    k_d     = k_q;
    len_d   = len_q;
    nrows_d = nrows_q;
    abase_d = abase_q;
    bbase_d = bbase_q;
    rbase_d = rbase_q;
    res_d   = res_q;
    rdone_d = rdone_q;
    done_d  = done_q;
    v1_d    = v1_q;
    v9_d    = v9_q;
    mv_d    = (state_q == S_RUN);
    ml_d    = (state_q == S_RUN) & k_last;
    unique case (state_q)
      S_IDLE: begin
        if (go) begin
          len_d   = bus.host_regs[2];
          nrows_d = bus.host_regs[3];
          abase_d = bus.host_regs[4];
          bbase_d = bus.host_regs[5];
          rbase_d = bus.host_regs[6];
          row_d   = '0;
          k_d     = '0;
          rdone_d = '0;
          done_d  = 1'b0;
          v1_d    = 1'b0;
          v9_d    = 1'b0;
          if (bus.host_regs[2] == '0 ||
              bus.host_regs[3] == '0)
            state_d = S_FIN;
          else
            state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (k_last) begin
          k_d     = '0;
          state_d = S_WAIT;
        end else begin
          k_d = k_q + 32'd1;
        end
      end
      S_WAIT: begin
        if (bus.mac_done) begin
          res_d   = bus.mac_result;
          state_d = S_WR;
        end
      end
      S_WR: begin
        rdone_d = rdone_q + 32'd1;
        row_d   = row_q + 32'd1;
        if (row_q + 32'd1 == nrows_q)
          state_d = S_FIN;
        else
          state_d = S_RUN;
      end
      S_FIN: begin
        done_d  = 1'b1;
        v1_d    = 1'b1;
        v9_d    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.xlr_mem_rd    = '0;
    bus.xlr_mem_wr    = '0;
    bus.xlr_mem_addr  = '0;
    bus.xlr_mem_be    = '0;
    bus.xlr_mem_wdata = '0;
    bus.mac_start     = 1'b0;
    if (state_q == S_RUN) begin
      bus.xlr_mem_rd      = 2'b11;
      bus.xlr_mem_addr[0] = a_addr;
      bus.xlr_mem_addr[1] = b_addr;
      bus.mac_start       = (k_q == '0);
    end
    if (state_q == S_WR) begin
      bus.xlr_mem_wr[1]   = 1'b1;
      bus.xlr_mem_addr[1] = r_addr;
      bus.xlr_mem_be[1]   = 32'hF << {row_q[2:0], 2'b00};
      bus.xlr_mem_wdata[1][row_q[2:0]] = res_q;
    end
  end

  assign bus.mac_valid = mv_q;
  assign bus.mac_last  = ml_q;
  assign bus.mac_a = mv_q ? bus.xlr_mem_rdata[0] : '0;
  assign bus.mac_b = mv_q ? bus.xlr_mem_rdata[1] : '0;

  always_comb begin
    bus.host_regs_data_out     = '0;
    bus.host_regs_valid_out    = '0;
    bus.host_regs_data_out[1]  = {31'd0, done_q};
    bus.host_regs_data_out[9]  = rdone_q;
    bus.host_regs_valid_out[1] = v1_q;
    bus.host_regs_valid_out[9] = v9_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      k_q     <= '0;
      len_q   <= '0;
      nrows_q <= '0;
      abase_q <= '0;
      bbase_q <= '0;
      rbase_q <= '0;
      res_q   <= '0;
      rdone_q <= '0;
      done_q  <= 1'b0;
      v1_q    <= 1'b0;
      v9_q    <= 1'b0;
      mv_q    <= 1'b0;
      ml_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      k_q     <= k_d;
      len_q   <= len_d;
      nrows_q <= nrows_d;
      abase_q <= abase_d;
      bbase_q <= bbase_d;
      rbase_q <= rbase_d;
      res_q   <= res_d;
      rdone_q <= rdone_d;
      done_q  <= done_d;
      v1_q    <= v1_d;
      v9_q    <= v9_d;
      mv_q    <= mv_d;
      ml_q    <= ml_d;
    end
  end
endmodule
